// File: rtl/id_ex_seg_reg_if.sv
// ----------------------------------------------------------------------------
// id_ex_seg_reg_if
//   Bundle of the signals that cross the ID->EX segment register.
//   *D signals come from the ID stage: the control decoder and the register-file
//   read. *E signals are the registered copies that the EX stage consumes.
//
//   modport master : ID-side view. Drives the *D fields and may observe the *E fields.
//   modport slave  : segment-register view. Reads the *D fields and drives the *E fields.
//
//   Fields
//     Valid      1         instruction-valid tag
//     PC         XLEN      instruction PC
//     RegOut1/2  XLEN      rs1 / rs2 read data
//     Imm        XLEN      sign-extended immediate
//     Rs1/Rs2/Rd REGIDX_W  register indices
//     Jal/Jalr   1         jump flags
//     RegWrite   3         load / write-back type
//     MemToReg   1         result comes from data memory
//     MemWrite   4         per-byte store enables
//     LoadNpc    1         write PC+4 to rd
//     RegRead    2         [1] uses rs1, [0] uses rs2
//     BranchType 3         branch condition
//     AluType    4         ALU operation
//     AluSrc1    1         ALU op1 select (1 = PC)
//     AluSrc2    2         ALU op2 select
// ----------------------------------------------------------------------------
interface id_ex_seg_reg_if #(
  parameter int XLEN     = 32,
  parameter int REGIDX_W = 5
);
  // ID-side fields
  logic                ValidD;
  logic [XLEN-1:0]     PCD;
  logic [XLEN-1:0]     RegOut1D;
  logic [XLEN-1:0]     RegOut2D;
  logic [XLEN-1:0]     ImmD;
  logic [REGIDX_W-1:0] Rs1D;
  logic [REGIDX_W-1:0] Rs2D;
  logic [REGIDX_W-1:0] RdD;
  logic                JalD;
  logic                JalrD;
  logic [2:0]          RegWriteD;
  logic                MemToRegD;
  logic [3:0]          MemWriteD;
  logic                LoadNpcD;
  logic [1:0]          RegReadD;
  logic [2:0]          BranchTypeD;
  logic [3:0]          AluTypeD;
  logic                AluSrc1D;
  logic [1:0]          AluSrc2D;

  // EX-side fields
  logic                ValidE;
  logic [XLEN-1:0]     PCE;
  logic [XLEN-1:0]     RegOut1E;
  logic [XLEN-1:0]     RegOut2E;
  logic [XLEN-1:0]     ImmE;
  logic [REGIDX_W-1:0] Rs1E;
  logic [REGIDX_W-1:0] Rs2E;
  logic [REGIDX_W-1:0] RdE;
  logic                JalE;
  logic                JalrE;
  logic [2:0]          RegWriteE;
  logic                MemToRegE;
  logic [3:0]          MemWriteE;
  logic                LoadNpcE;
  logic [1:0]          RegReadE;
  logic [2:0]          BranchTypeE;
  logic [3:0]          AluTypeE;
  logic                AluSrc1E;
  logic [1:0]          AluSrc2E;

  modport master (
    output ValidD, PCD, RegOut1D, RegOut2D, ImmD, Rs1D, Rs2D, RdD, JalD, JalrD,
           RegWriteD, MemToRegD, MemWriteD, LoadNpcD, RegReadD, BranchTypeD,
           AluTypeD, AluSrc1D, AluSrc2D,
    input  ValidE, PCE, RegOut1E, RegOut2E, ImmE, Rs1E, Rs2E, RdE, JalE, JalrE,
           RegWriteE, MemToRegE, MemWriteE, LoadNpcE, RegReadE, BranchTypeE,
           AluTypeE, AluSrc1E, AluSrc2E
  );

  modport slave (
    input  ValidD, PCD, RegOut1D, RegOut2D, ImmD, Rs1D, Rs2D, RdD, JalD, JalrD,
           RegWriteD, MemToRegD, MemWriteD, LoadNpcD, RegReadD, BranchTypeD,
           AluTypeD, AluSrc1D, AluSrc2D,
    output ValidE, PCE, RegOut1E, RegOut2E, ImmE, Rs1E, Rs2E, RdE, JalE, JalrE,
           RegWriteE, MemToRegE, MemWriteE, LoadNpcE, RegReadE, BranchTypeE,
           AluTypeE, AluSrc1E, AluSrc2E
  );
endinterface

// File: rtl/id_ex_seg_reg.sv
// ----------------------------------------------------------------------------
// id_ex_seg_reg
//   ID->EX pipeline segment register of the 5-stage RV32IM core.
//   All EX-side fields are flops. There is no combinational path from D to E.
//
//   Ports
//     clk    in  core clock; all updates happen on the rising edge
//     rst    in  asynchronous active-high reset; forces the bubble word
//     en     in  1 = may update, 0 = hold (stall E); en=0 overrides clear
//     clear  in  1 = load a bubble instead of the D fields (flush E)
//     bus    slave modport of id_ex_seg_reg_if (D fields in, E fields out)
//
//   The bubble word is all zeros, except for these fields:
//     RegWrite   = NOREGWRITE
//     BranchType = NOBRANCH
//     AluType    = ALU_ADD
//   These three encodings are parameters. Set them to match the core's
//   Parameters.v.
// ----------------------------------------------------------------------------
module id_ex_seg_reg #(
  parameter int         XLEN       = 32,
  parameter int         REGIDX_W   = 5,
  parameter logic [2:0] NOREGWRITE = 3'd0,
  parameter logic [2:0] NOBRANCH   = 3'd0,
  parameter logic [3:0] ALU_ADD    = 4'd3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clear,
  id_ex_seg_reg_if.slave bus
);

  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     reg_out1;
    logic [XLEN-1:0]     reg_out2;
    logic [XLEN-1:0]     imm;
    logic [REGIDX_W-1:0] rs1;
    logic [REGIDX_W-1:0] rs2;
    logic [REGIDX_W-1:0] rd;
    logic                jal;
    logic                jalr;
    logic [2:0]          reg_write;
    logic                mem_to_reg;
    logic [3:0]          mem_write;
    logic                load_npc;
    logic [1:0]          reg_read;
    logic [2:0]          branch_type;
    logic [3:0]          alu_type;
    logic                alu_src1;
    logic [1:0]          alu_src2;
  } ex_word_t;

  // A bubble writes nothing, stores nothing, and does not branch or jump.
  // RegRead=00 keeps it invisible to the forwarding unit.
  function automatic ex_word_t bubble_word();
    ex_word_t w;
    w             = '0;
    w.reg_write   = NOREGWRITE;
    w.branch_type = NOBRANCH;
    w.alu_type    = ALU_ADD;
    return w;
  endfunction

  ex_word_t d_word_s;
  ex_word_t next_word_s;
  ex_word_t ex_word_r;

  // Gather the ID-side fields into one word.
  always_comb begin
    d_word_s             = '0;
    d_word_s.valid       = bus.ValidD;
    d_word_s.pc          = bus.PCD;
    d_word_s.reg_out1    = bus.RegOut1D;
    d_word_s.reg_out2    = bus.RegOut2D;
    d_word_s.imm         = bus.ImmD;
    d_word_s.rs1         = bus.Rs1D;
    d_word_s.rs2         = bus.Rs2D;
    d_word_s.rd          = bus.RdD;
    d_word_s.jal         = bus.JalD;
    d_word_s.jalr        = bus.JalrD;
    d_word_s.reg_write   = bus.RegWriteD;
    d_word_s.mem_to_reg  = bus.MemToRegD;
    d_word_s.mem_write   = bus.MemWriteD;
    d_word_s.load_npc    = bus.LoadNpcD;
    d_word_s.reg_read    = bus.RegReadD;
    d_word_s.branch_type = bus.BranchTypeD;
    d_word_s.alu_type    = bus.AluTypeD;
    d_word_s.alu_src1    = bus.AluSrc1D;
    d_word_s.alu_src2    = bus.AluSrc2D;
  end

  // Select the word to load when enabled.
  // ValidD=0 is still captured verbatim; the decoder keeps those controls harmless.
  always_comb begin
    next_word_s = d_word_s;
    if (clear) begin
      next_word_s = bubble_word();
    end else begin
      next_word_s = d_word_s;
    end
  end

  // Segment register. A stall (en=0) takes priority over a flush, so a
  // stalled instruction is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_word_r <= bubble_word();
    end else if (en) begin
      ex_word_r <= next_word_s;
    end else begin
      ex_word_r <= ex_word_r;
    end
  end

  assign bus.ValidE      = ex_word_r.valid;
  assign bus.PCE         = ex_word_r.pc;
  assign bus.RegOut1E    = ex_word_r.reg_out1;
  assign bus.RegOut2E    = ex_word_r.reg_out2;
  assign bus.ImmE        = ex_word_r.imm;
  assign bus.Rs1E        = ex_word_r.rs1;
  assign bus.Rs2E        = ex_word_r.rs2;
  assign bus.RdE         = ex_word_r.rd;
  assign bus.JalE        = ex_word_r.jal;
  assign bus.JalrE       = ex_word_r.jalr;
  assign bus.RegWriteE   = ex_word_r.reg_write;
  assign bus.MemToRegE   = ex_word_r.mem_to_reg;
  assign bus.MemWriteE   = ex_word_r.mem_write;
  assign bus.LoadNpcE    = ex_word_r.load_npc;
  assign bus.RegReadE    = ex_word_r.reg_read;
  assign bus.BranchTypeE = ex_word_r.branch_type;
  assign bus.AluTypeE    = ex_word_r.alu_type;
  assign bus.AluSrc1E    = ex_word_r.alu_src1;
  assign bus.AluSrc2E    = ex_word_r.alu_src2;

endmodule

// File: tb/tb_id_ex_seg_reg.sv
// ----------------------------------------------------------------------------
// tb_id_ex_seg_reg
//   Self-checking bench for id_ex_seg_reg.
//   The reference model keeps the expected E-side word as one flat vector.
//   It updates that vector from the hold / flush / load rules, and uses a
//   queue for the back-to-back run.
// ----------------------------------------------------------------------------
module tb_id_ex_seg_reg;
  localparam int XLEN     = 32;
  localparam int REGIDX_W = 5;
  localparam int VW       = 167;

  localparam logic [2:0] NOREGWRITE = 3'd0;
  localparam logic [2:0] NOBRANCH   = 3'd0;
  localparam logic [3:0] ALU_ADD    = 4'd3;

  // Bubble, in the field order used by pack_d/pack_e.
  localparam logic [VW-1:0] BUBBLE = {1'b0, 128'd0, 15'd0, 1'b0, 1'b0, NOREGWRITE,
                                      1'b0, 4'b0000, 1'b0, 2'b00, NOBRANCH, ALU_ADD,
                                      1'b0, 2'b00};

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic clear;

  int errors = 0;
  int checks = 0;

  logic [VW-1:0] exp_q;
  logic [VW-1:0] sb_q[$];

  id_ex_seg_reg_if #(.XLEN(XLEN), .REGIDX_W(REGIDX_W)) bus();

  id_ex_seg_reg #(
    .XLEN(XLEN), .REGIDX_W(REGIDX_W),
    .NOREGWRITE(NOREGWRITE), .NOBRANCH(NOBRANCH), .ALU_ADD(ALU_ADD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Counts one comparison and reports any mismatch.
  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack_d();
    return {bus.ValidD, bus.PCD, bus.RegOut1D, bus.RegOut2D, bus.ImmD, bus.Rs1D,
            bus.Rs2D, bus.RdD, bus.JalD, bus.JalrD, bus.RegWriteD, bus.MemToRegD,
            bus.MemWriteD, bus.LoadNpcD, bus.RegReadD, bus.BranchTypeD,
            bus.AluTypeD, bus.AluSrc1D, bus.AluSrc2D};
  endfunction

  function automatic logic [VW-1:0] pack_e();
    return {bus.ValidE, bus.PCE, bus.RegOut1E, bus.RegOut2E, bus.ImmE, bus.Rs1E,
            bus.Rs2E, bus.RdE, bus.JalE, bus.JalrE, bus.RegWriteE, bus.MemToRegE,
            bus.MemWriteE, bus.LoadNpcE, bus.RegReadE, bus.BranchTypeE,
            bus.AluTypeE, bus.AluSrc1E, bus.AluSrc2E};
  endfunction

  task automatic rand_d();
    bus.ValidD      = 1'($urandom);
    bus.PCD         = $urandom;
    bus.RegOut1D    = $urandom;
    bus.RegOut2D    = $urandom;
    bus.ImmD        = $urandom;
    bus.Rs1D        = 5'($urandom);
    bus.Rs2D        = 5'($urandom);
    bus.RdD         = 5'($urandom);
    bus.JalD        = 1'($urandom);
    bus.JalrD       = 1'($urandom);
    bus.RegWriteD   = 3'($urandom);
    bus.MemToRegD   = 1'($urandom);
    bus.MemWriteD   = 4'($urandom);
    bus.LoadNpcD    = 1'($urandom);
    bus.RegReadD    = 2'($urandom);
    bus.BranchTypeD = 3'($urandom);
    bus.AluTypeD    = 4'($urandom);
    bus.AluSrc1D    = 1'($urandom);
    bus.AluSrc2D    = 2'($urandom);
  endtask

  // One clock edge: apply the register rules to the model, then compare.
  task automatic step(input string tag);
    logic [VW-1:0] nxt;
    if (rst)        nxt = BUBBLE;
    else if (!en)   nxt = exp_q;
    else if (clear) nxt = BUBBLE;
    else            nxt = pack_d();
    @(posedge clk);
    #1;
    exp_q = nxt;
    check(tag, pack_e(), exp_q);
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    clear = 1'b0;
    rand_d();
    exp_q = BUBBLE;
    #1;
    check("reset_state", pack_e(), BUBBLE);
    @(posedge clk);
    #1;
    check("reset_hold_edge", pack_e(), BUBBLE);
    #3;
    rst = 1'b0;

    // Pass-through
    en = 1'b1;
    rand_d();
    bus.PCD = 32'h0000_1000; bus.AluTypeD = 4'h8; bus.MemWriteD = 4'b0011;
    bus.ValidD = 1'b1; bus.JalD = 1'b1; bus.RegWriteD = 3'd2;
    step("pass_word");
    check("pass_pc",     VW'(bus.PCE),       VW'(32'h0000_1000));
    check("pass_alu",    VW'(bus.AluTypeE),  VW'(4'h8));
    check("pass_mw",     VW'(bus.MemWriteE), VW'(4'b0011));
    check("pass_valid",  VW'(bus.ValidE),    VW'(1'b1));

    // Asynchronous reset mid-cycle
    rand_d();
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", VW'(bus.ValidE),    VW'(1'b0));
    check("arst_rw",    VW'(bus.RegWriteE), VW'(NOREGWRITE));
    check("arst_mw",    VW'(bus.MemWriteE), VW'(4'b0000));
    check("arst_jal",   VW'(bus.JalE),      VW'(1'b0));
    check("arst_word",  pack_e(),           BUBBLE);
    exp_q = BUBBLE;
    step("arst_hold");
    #3;
    rst = 1'b0;

    // Stall for three cycles
    rand_d();
    bus.PCD = 32'h0000_2000;
    step("stall_load");
    en = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      rand_d();
      bus.PCD = 32'h0000_2000 + 32'(4 * i);
      step("stall_word");
      check("stall_pc", VW'(bus.PCE), VW'(32'h0000_2000));
    end
    en = 1'b1;
    step("stall_release");
    check("release_pc", VW'(bus.PCE), VW'(32'h0000_200C));

    // Flush after a store
    rand_d();
    bus.MemWriteD = 4'b1111; bus.ValidD = 1'b1; bus.RegReadD = 2'b11;
    step("store_load");
    check("store_mw", VW'(bus.MemWriteE), VW'(4'b1111));
    clear = 1'b1;
    rand_d();
    step("flush_word");
    check("flush_mw",    VW'(bus.MemWriteE),   VW'(4'b0000));
    check("flush_rr",    VW'(bus.RegReadE),    VW'(2'b00));
    check("flush_br",    VW'(bus.BranchTypeE), VW'(NOBRANCH));
    check("flush_valid", VW'(bus.ValidE),      VW'(1'b0));
    clear = 1'b0;

    // Stall and flush together: stall wins
    rand_d();
    bus.JalD = 1'b1;
    step("jal_load");
    en = 1'b0; clear = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_d();
      step("stallflush_word");
      check("stallflush_jal", VW'(bus.JalE), VW'(1'b1));
    end
    en = 1'b1; clear = 1'b0;

    // Back-to-back: scoreboard of D words delayed by one edge
    for (int i = 0; i < 8; i++) begin
      rand_d();
      sb_q.push_back(pack_d());
      @(posedge clk);
      #1;
      exp_q = sb_q.pop_front();
      check("b2b_word", pack_e(), exp_q);
    end

    // Random mix of enable and flush
    for (int i = 0; i < 200; i++) begin
      rand_d();
      en    = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 4) == 0);
      step("mix_word");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
